seq_alu: RTL and testbench

Parametrised, handshaked execution unit for the RV32IC core. It keeps the existing ALU select codes: AND `0000`, OR `0001`, ADD `0010` and SUB `0110`. It extends them to the full RV32I register-register set plus M-extension multiply, divide and remainder. Single-cycle ops return one cycle after acceptance; multiply and divide run on an iterative shift-add/shift-subtract datapath for WIDTH cycles. It sits between decode/issue and writeback, and the pipeline stalls on `in_ready` and `out_valid`.

---
 rtl/seq_alu_if.sv | 26 ++
 rtl/seq_alu.sv | 180 ++++++++++++++++++
 tb/tb_seq_alu.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// Issue/result bus between decode/issue and the sequential execution unit.
// The master side issues operands and consumes results; the slave side is the unit.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;
    logic             z;

    modport master (
        output flush, in_valid, sel, a, b, out_ready,
        input  in_ready, out_valid, c, z
    );

    modport slave (
        input  flush, in_valid, sel, a, b, out_ready,
        output in_ready, out_valid, c, z
    );
endinterface

// File: rtl/seq_alu.sv
// Handshaked execution unit: single-cycle logic/add/shift/compare ops and
// iterative radix-2 multiply (shift-add) and divide (restoring) taking WIDTH steps.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input logic      clk,
    input logic      rst_n,
    seq_alu_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CNW = SHW + 1;
    localparam logic [CNW-1:0] LAST_STEP = CNW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]       op_q;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;
    logic             neg_q;
    logic             neg_r;
    logic [CNW-1:0]   count;

    logic             accept;
    logic             single_op;
    logic             is_mul_sel;
    logic             signed_div;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH-1:0] final_res;

    assign accept     = bus.in_valid && (state == IDLE);
    assign single_op  = !bus.sel[3] || (bus.sel[3:1] == 3'b100);
    assign is_mul_sel = (bus.sel[3:2] == 2'b10);
    assign signed_div = (bus.sel[3:2] == 2'b11) && !bus.sel[0];
    assign shamt      = bus.b[SHW-1:0];
    assign abs_a      = (signed_div && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign abs_b      = (signed_div && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.c         = c_q;
    assign bus.z         = (c_q == '0);

    // Single-cycle result computed straight from the live operands at accept time.
    always_comb begin
        alu_res = '0;
        case (bus.sel)
            4'b0000: alu_res = bus.a & bus.b;
            4'b0001: alu_res = bus.a | bus.b;
            4'b0010: alu_res = bus.a + bus.b;
            4'b0011: alu_res = bus.a ^ bus.b;
            4'b0100: alu_res = bus.a << shamt;
            4'b0101: alu_res = bus.a >> shamt;
            4'b0110: alu_res = bus.a - bus.b;
            4'b0111: alu_res = WIDTH'($signed(bus.a) >>> shamt);
            4'b1000: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            4'b1001: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            default: alu_res = '0;
        endcase
    end

    // One radix-2 step: multiply shifts the partial product right, divide shifts the remainder left.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        step_hi   = acc_hi;
        step_lo   = acc_lo;
        if (op_q[3:2] == 2'b10) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
            step_hi = div_diff[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            step_hi = div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end

    // Pick the product half or apply signs to quotient/remainder; divide by zero forces an all-ones quotient.
    always_comb begin
        final_res = '0;
        case (op_q)
            4'b1010:          final_res = acc_lo;
            4'b1011:          final_res = acc_hi;
            4'b1100, 4'b1101: final_res = (opnd == '0) ? '1 : (neg_q ? -acc_lo : acc_lo);
            4'b1110, 4'b1111: final_res = neg_r ? -acc_hi : acc_hi;
            default:          final_res = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; flush overrides both accept and the result handshake.
    always_comb begin
        state_next = state;
        if (bus.flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (accept) state_next = single_op ? DONE : CALC;
                CALC: if (count == LAST_STEP) state_next = DONE;
                DONE: if (bus.out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Operand capture, iteration registers and the result register; a flush freezes all of them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            c_q    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            count  <= '0;
        end else if (!bus.flush) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q <= bus.sel;
                        if (single_op) begin
                            c_q <= alu_res;
                        end else begin
                            count  <= '0;
                            acc_hi <= '0;
                            neg_q  <= signed_div && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            neg_r  <= signed_div && bus.a[WIDTH-1];
                            if (is_mul_sel) begin
                                acc_lo <= bus.b;
                                opnd   <= bus.a;
                            end else begin
                                acc_lo <= abs_a;
                                opnd   <= abs_b;
                            end
                        end
                    end
                end
                CALC: begin
                    if (count == LAST_STEP) begin
                        c_q <= final_res;
                    end else begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        count  <= count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH = 32.
module tb_seq_alu;
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_DIV  = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;
    localparam logic [3:0] OP_REM  = 4'b1110;
    localparam logic [3:0] OP_REMU = 4'b1111;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    int   lat;
    int   seen;

    seq_alu_if #(.WIDTH(32)) bus ();

    seq_alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something hangs beyond every per-wait bound.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one op, wait for acceptance, scramble inputs, then count cycles to out_valid.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] op_a, input logic [31:0] op_b,
                                 output int latency);
        int guard;
        bus.sel      = op;
        bus.a        = op_a;
        bus.b        = op_b;
        bus.in_valid = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            tick();
            guard++;
        end
        tick();
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.sel      = 4'($urandom);
        latency = 0;
        do begin
            tick();
            latency++;
        end while (!bus.out_valid && latency < 100);
    endtask

    task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] op_a,
                         input logic [31:0] op_b, input logic [31:0] exp_c, input int exp_lat);
        int l;
        applyStimulus(op, op_a, op_b, l);
        checkOutput({tag, "_c"}, bus.c, exp_c);
        checkOutput({tag, "_z"}, 32'(bus.z), 32'(exp_c == 32'h0));
        checkOutput({tag, "_lat"}, 32'(l), 32'(exp_lat));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checkOutput({tag, "_rdy_after"}, {30'h0, bus.in_ready, bus.out_valid}, 32'h2);
    endtask

    // Linear sequence of directed steps.
    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.sel       = 4'h0;
        bus.a         = 32'h0;
        bus.b         = 32'h0;
        bus.out_ready = 1'b0;

        repeat (3) tick();
        checkOutput("rst_c", bus.c, 32'h0);
        checkOutput("rst_z", 32'(bus.z), 32'h1);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'h1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'h0);
        rst_n = 1'b1;
        tick();

        runOp("add_wrap", OP_ADD,  32'hFFFFFFFF, 32'h1,        32'h00000000, 1);
        runOp("sub_neg",  OP_SUB,  32'h5,        32'h7,        32'hFFFFFFFE, 1);
        runOp("and",      OP_AND,  32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1);
        runOp("or",       OP_OR,   32'hFF00FF00, 32'h0FF00FF0, 32'hFFF0FFF0, 1);
        runOp("xor",      OP_XOR,  32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1);
        runOp("sra",      OP_SRA,  32'h80000000, 32'h00000024, 32'hF8000000, 1);
        runOp("srl",      OP_SRL,  32'h80000000, 32'h00000024, 32'h08000000, 1);
        runOp("sll",      OP_SLL,  32'h1,        32'd31,       32'h80000000, 1);
        runOp("slt",      OP_SLT,  32'hFFFFFFFF, 32'h1,        32'h1,        1);
        runOp("sltu",     OP_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,        1);

        runOp("mul",      OP_MUL,   32'h12345678, 32'h10,       32'h23456780, 33);
        runOp("mulhu",    OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
        runOp("div_neg",  OP_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 33);
        runOp("rem_neg",  OP_REM,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 33);
        runOp("divu_z",   OP_DIVU,  32'h1234,     32'h0,        32'hFFFFFFFF, 33);
        runOp("remu_z",   OP_REMU,  32'h1234,     32'h0,        32'h00001234, 33);
        runOp("div_ovf",  OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
        runOp("rem_ovf",  OP_REM,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);
        runOp("divu",     OP_DIVU,  32'd100,      32'd7,        32'd14,       33);

        // Backpressure: result held while a new request is pending.
        applyStimulus(OP_ADD, 32'd10, 32'd20, lat);
        checkOutput("bp_first_c", bus.c, 32'd30);
        bus.sel      = OP_SUB;
        bus.a        = 32'd100;
        bus.b        = 32'd1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp_hold_c", bus.c, 32'd30);
            checkOutput("bp_hold_flags", {29'h0, bus.out_valid, bus.in_ready, bus.z}, 32'h4);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checkOutput("bp_release_rdy", 32'(bus.in_ready), 32'h1);
        runOp("bp_next", OP_SUB, 32'd100, 32'd1, 32'd99, 1);

        // Abort by flush on cycle 10 of a divide.
        bus.sel      = OP_DIVU;
        bus.a        = 32'h1234;
        bus.b        = 32'h3;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checkOutput("flush_rdy", {30'h0, bus.in_ready, bus.out_valid}, 32'h2);
        checkOutput("flush_c_kept", bus.c, 32'd99);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        checkOutput("flush_no_result", 32'(seen), 32'h0);
        runOp("flush_add", OP_ADD, 32'd2, 32'd3, 32'd5, 1);

        // Abort by asynchronous reset on cycle 10 of a divide.
        bus.sel      = OP_DIVU;
        bus.a        = 32'h1234;
        bus.b        = 32'h3;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        #2;
        checkOutput("arst_c", bus.c, 32'h0);
        checkOutput("arst_flags", {29'h0, bus.in_ready, bus.out_valid, bus.z}, 32'h5);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("arst_rdy", 32'(bus.in_ready), 32'h1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        checkOutput("arst_no_result", 32'(seen), 32'h0);
        runOp("arst_add", OP_ADD, 32'd2, 32'd3, 32'd5, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
